cdb_arbiter: RTL and testbench

- Shares the 16-bit common data bus (CDB) between the two result producers: the arithmetic ULA (source 1) and the load/store ULA (source 0).
- Each producer pushes completed result words into a private FIFO. The arbiter drives one word per cycle onto the CDB, round-robin, registered.
- Sits between the execution units and the register file / reservation stations that snoop the CDB.

---
 rtl/cdb_pkg.sv | 23 ++
 rtl/cdb_src_fifo.sv | 50 +++++
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB word layout, source ids and idle value for the CDB arbiter and its FIFOs.
// Latency: none (declarations only). Backpressure: not applicable.
// Also holds the destination-field format check used at accept time.
package cdb_pkg;

    localparam int DEST_MSB = 15;
    localparam int DEST_LSB = 13;
    localparam int RS_MSB   = 12;
    localparam int RS_LSB   = 11;
    localparam int SRC_BIT  = 10;
    localparam int DATA_MSB = 9;
    localparam int DATA_LSB = 0;

    localparam logic SRC_ULA  = 1'b1;
    localparam logic SRC_LDSD = 1'b0;

    localparam logic [15:0] CDB_IDLE_WORD = 16'hFFFF;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: DEPTH x WIDTH circular buffer with count-based ready.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: o_ready low while full or in reset; pops of an empty FIFO are ignored.
module cdb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    // Ready looks only at the stored count, never at a same-cycle pop.
    assign o_ready = i_reset_n && (r_count < FULL_CNT);
    assign w_push  = i_push & o_ready;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between the ULA (source 1) and load/store ULA (source 0).
// Latency: one cycle from grant decision to registered CDB word; accept-to-CDB is at least 1 cycle.
// Backpressure: per-source FIFO ready; i_cdb_hold blocks grants but not accepts.
module cdb_arbiter import cdb_pkg::*; #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] IDLE_WORD = CDB_IDLE_WORD
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_ula_word,
    input  logic             i_ula_valid,
    output logic             o_ula_ready,
    input  logic [WIDTH-1:0] i_ldsd_word,
    input  logic             i_ldsd_valid,
    output logic             o_ldsd_ready,
    input  logic             i_cdb_hold,
    output logic [WIDTH-1:0] o_cdb_data,
    output logic             o_cdb_valid,
    output logic             o_grant_ula,
    output logic             o_grant_ldsd,
    output logic             o_fmt_err
);
    logic             w_ula_acc,  w_ula_bad,  w_ula_push,  w_ula_empty;
    logic             w_ldsd_acc, w_ldsd_bad, w_ldsd_push, w_ldsd_empty;
    logic [WIDTH-1:0] w_ula_tag,  w_ldsd_tag;
    logic [WIDTH-1:0] w_ula_head, w_ldsd_head;
    logic             w_gnt_ula,  w_gnt_ldsd;

    logic             r_prio_ula;
    logic [WIDTH-1:0] r_cdb_data;
    logic             r_cdb_valid;
    logic             r_grant_ula;
    logic             r_grant_ldsd;
    logic             r_fmt_err;

    // Malformed words still complete the handshake; they are just not stored.
    assign w_ula_acc   = i_ula_valid & o_ula_ready;
    assign w_ula_bad   = w_ula_acc & ~is_onehot3(i_ula_word[DEST_MSB:DEST_LSB]);
    assign w_ula_push  = w_ula_acc & ~w_ula_bad;
    assign w_ldsd_acc  = i_ldsd_valid & o_ldsd_ready;
    assign w_ldsd_bad  = w_ldsd_acc & ~is_onehot3(i_ldsd_word[DEST_MSB:DEST_LSB]);
    assign w_ldsd_push = w_ldsd_acc & ~w_ldsd_bad;

    always_comb begin
        w_ula_tag           = i_ula_word;
        w_ula_tag[SRC_BIT]  = SRC_ULA;
        w_ldsd_tag          = i_ldsd_word;
        w_ldsd_tag[SRC_BIT] = SRC_LDSD;
    end

    cdb_src_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ula_fifo (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_push     (w_ula_push),
        .i_push_dat (w_ula_tag),
        .i_pop      (w_gnt_ula),
        .o_head_dat (w_ula_head),
        .o_empty    (w_ula_empty),
        .o_ready    (o_ula_ready)
    );

    cdb_src_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ldsd_fifo (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_push     (w_ldsd_push),
        .i_push_dat (w_ldsd_tag),
        .i_pop      (w_gnt_ldsd),
        .o_head_dat (w_ldsd_head),
        .o_empty    (w_ldsd_empty),
        .o_ready    (o_ldsd_ready)
    );

    // r_prio_ula selects the winner only when both sources have a word waiting.
    always_comb begin
        w_gnt_ula  = 1'b0;
        w_gnt_ldsd = 1'b0;
        if (!i_cdb_hold) begin
            if (!w_ula_empty && !w_ldsd_empty) begin
                w_gnt_ula  = r_prio_ula;
                w_gnt_ldsd = ~r_prio_ula;
            end else begin
                w_gnt_ula  = ~w_ula_empty;
                w_gnt_ldsd = ~w_ldsd_empty;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_prio_ula   <= 1'b1;
            r_cdb_data   <= IDLE_WORD;
            r_cdb_valid  <= 1'b0;
            r_grant_ula  <= 1'b0;
            r_grant_ldsd <= 1'b0;
            r_fmt_err    <= 1'b0;
        end else begin
            r_cdb_valid  <= w_gnt_ula | w_gnt_ldsd;
            r_grant_ula  <= w_gnt_ula;
            r_grant_ldsd <= w_gnt_ldsd;
            r_fmt_err    <= w_ula_bad | w_ldsd_bad;
            if (w_gnt_ula)       r_cdb_data <= w_ula_head;
            else if (w_gnt_ldsd) r_cdb_data <= w_ldsd_head;
            else                 r_cdb_data <= IDLE_WORD;
            if (w_gnt_ula)       r_prio_ula <= 1'b0;
            else if (w_gnt_ldsd) r_prio_ula <= 1'b1;
        end
    end

    assign o_cdb_data   = r_cdb_data;
    assign o_cdb_valid  = r_cdb_valid;
    assign o_grant_ula  = r_grant_ula;
    assign o_grant_ldsd = r_grant_ldsd;
    assign o_fmt_err    = r_fmt_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then randomized traffic against a queue model.
module tb_cdb_arbiter;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] ula_word, ldsd_word;
    logic        ula_valid, ldsd_valid, hold;
    logic        ula_ready, ldsd_ready;
    logic [15:0] cdb_data;
    logic        cdb_valid, grant_ula, grant_ldsd, fmt_err;

    int nvec = 0;
    int nerr = 0;

    cdb_arbiter #(.DEPTH(DEPTH), .WIDTH(16), .IDLE_WORD(16'hFFFF)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_ula_word   (ula_word),
        .i_ula_valid  (ula_valid),
        .o_ula_ready  (ula_ready),
        .i_ldsd_word  (ldsd_word),
        .i_ldsd_valid (ldsd_valid),
        .o_ldsd_ready (ldsd_ready),
        .i_cdb_hold   (hold),
        .o_cdb_data   (cdb_data),
        .o_cdb_valid  (cdb_valid),
        .o_grant_ula  (grant_ula),
        .o_grant_ldsd (grant_ldsd),
        .o_fmt_err    (fmt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected/observed outputs packed as {data, valid, grant_ula, grant_ldsd, fmt_err, ula_ready, ldsd_ready}
    typedef struct {
        logic        rst_n;
        logic        hold;
        logic        uv;
        logic [15:0] uw;
        logic        lv;
        logic [15:0] lw;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic h,
                                input logic uv, input logic [15:0] uw,
                                input logic lv, input logic [15:0] lw,
                                input logic [15:0] d, input logic v, input logic gu,
                                input logic gl, input logic fe, input logic ur, input logic lr);
        vec_t t;
        t.rst_n = r; t.hold = h; t.uv = uv; t.uw = uw; t.lv = lv; t.lw = lw;
        t.exp = {d, v, gu, gl, fe, ur, lr};
        tbl.push_back(t);
    endfunction

    // Reference model: one queue per source plus "who wins the next tie".
    logic [15:0] m_qu[$];
    logic [15:0] m_ql[$];
    bit          m_prio_ula = 1'b1;
    logic [21:0] m_exp;

    function automatic void model_edge();
        logic [15:0] d;
        bit gu, gl, fe, ur_pre, lr_pre;
        d = 16'hFFFF; gu = 0; gl = 0; fe = 0;
        if (!rst_n) begin
            m_qu.delete();
            m_ql.delete();
            m_prio_ula = 1'b1;
        end else begin
            ur_pre = (m_qu.size() < DEPTH);
            lr_pre = (m_ql.size() < DEPTH);
            if (!hold) begin
                if (m_qu.size() > 0 && m_ql.size() > 0) begin
                    gu = m_prio_ula;
                    gl = !m_prio_ula;
                end else begin
                    gu = (m_qu.size() > 0);
                    gl = (m_ql.size() > 0);
                end
            end
            if (gu) begin d = m_qu.pop_front(); m_prio_ula = 1'b0; end
            if (gl) begin d = m_ql.pop_front(); m_prio_ula = 1'b1; end
            if (ula_valid && ur_pre) begin
                if ($countones(ula_word[15:13]) == 1) m_qu.push_back({ula_word[15:11], 1'b1, ula_word[9:0]});
                else fe = 1;
            end
            if (ldsd_valid && lr_pre) begin
                if ($countones(ldsd_word[15:13]) == 1) m_ql.push_back({ldsd_word[15:11], 1'b0, ldsd_word[9:0]});
                else fe = 1;
            end
        end
        m_exp = {d, 1'(gu || gl), 1'(gu), 1'(gl), 1'(fe),
                 1'(rst_n && m_qu.size() < DEPTH), 1'(rst_n && m_ql.size() < DEPTH)};
    endfunction

    function automatic logic [21:0] observed();
        return {cdb_data, cdb_valid, grant_ula, grant_ldsd, fmt_err, ula_ready, ldsd_ready};
    endfunction

    task automatic check(input string tag, input int idx, input logic [21:0] exp);
        logic [21:0] got;
        got = observed();
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s #%0d: got data=%h v=%b gu=%b gl=%b fe=%b ur=%b lr=%b, expected data=%h v=%b gu=%b gl=%b fe=%b ur=%b lr=%b",
                     tag, idx, got[21:6], got[5], got[4], got[3], got[2], got[1], got[0],
                     exp[21:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [2:0] dest;
        int r;
        r = $urandom_range(0, 7);
        if (r < 6) dest = 3'b001 << (r % 3);
        else       dest = 3'($urandom_range(0, 7));
        return {dest, 13'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0; hold = 1'b0;
        ula_valid = 1'b0; ula_word = '0;
        ldsd_valid = 1'b0; ldsd_word = '0;

        // reset, then idle
        add(0,0, 0,16'h0, 0,16'h0, 16'hFFFF,0,0,0,0,0,0);
        add(0,0, 0,16'h0, 0,16'h0, 16'hFFFF,0,0,0,0,0,0);
        for (int i = 0; i < 5; i++) add(1,0, 0,16'h0, 0,16'h0, 16'hFFFF,0,0,0,0,1,1);
        // simultaneous words: ULA wins first tie
        add(1,0, 1,16'h4C05, 1,16'h3007, 16'hFFFF,0,0,0,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'h4C05,1,1,0,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'h3007,1,0,1,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'hFFFF,0,0,0,0,1,1);
        // source bit overwritten for ld/sd
        add(1,0, 0,16'h0, 1,16'h3407, 16'hFFFF,0,0,0,0,1,1);
        add(1,0, 0,16'h0, 0,16'h0,    16'h3007,1,0,1,0,1,1);
        // both backlogged: strict alternation, ld/sd producer retries while not ready
        add(1,0, 1,16'h2401, 1,16'h2011, 16'hFFFF,0,0,0,0,1,1);
        add(1,0, 1,16'h4402, 1,16'h4012, 16'h2401,1,1,0,0,1,0);
        add(1,0, 1,16'h8403, 1,16'h8013, 16'h2011,1,0,1,0,0,1);
        add(1,0, 0,16'h0,    1,16'h8013, 16'h4402,1,1,0,0,1,0);
        add(1,0, 0,16'h0,    0,16'h0,    16'h4012,1,0,1,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'h8403,1,1,0,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'h8013,1,0,1,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'hFFFF,0,0,0,0,1,1);
        // hold: fill ULA FIFO, extra push ignored, then drain in order
        add(1,1, 1,16'h2001, 0,16'h0, 16'hFFFF,0,0,0,0,1,1);
        add(1,1, 1,16'h8155, 0,16'h0, 16'hFFFF,0,0,0,0,0,1);
        add(1,1, 1,16'h4C05, 0,16'h0, 16'hFFFF,0,0,0,0,0,1);
        add(1,0, 0,16'h0,    0,16'h0, 16'h2401,1,1,0,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0, 16'h8555,1,1,0,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0, 16'hFFFF,0,0,0,0,1,1);
        // malformed destinations
        add(1,0, 1,16'h6C05, 0,16'h0,    16'hFFFF,0,0,0,1,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'hFFFF,0,0,0,0,1,1);
        add(1,0, 1,16'h6C05, 1,16'h0005, 16'hFFFF,0,0,0,1,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'hFFFF,0,0,0,0,1,1);
        add(1,0, 1,16'h6C05, 1,16'h2011, 16'hFFFF,0,0,0,1,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'h2011,1,0,1,0,1,1);
        // reset discards queued words
        add(1,1, 1,16'h2001, 1,16'h2011, 16'hFFFF,0,0,0,0,1,1);
        add(0,1, 0,16'h0,    0,16'h0,    16'hFFFF,0,0,0,0,0,0);
        add(1,0, 0,16'h0,    0,16'h0,    16'hFFFF,0,0,0,0,1,1);
        add(1,0, 1,16'h4C05, 0,16'h0,    16'hFFFF,0,0,0,0,1,1);
        add(1,0, 0,16'h0,    0,16'h0,    16'h4C05,1,1,0,0,1,1);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; hold = tbl[i].hold;
            ula_valid = tbl[i].uv;  ula_word = tbl[i].uw;
            ldsd_valid = tbl[i].lv; ldsd_word = tbl[i].lw;
            model_edge();
            @(posedge clk);
            #1;
            check("table", i, tbl[i].exp);
        end

        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            hold       = ($urandom_range(0, 3) == 0);
            ula_valid  = ($urandom_range(0, 9) < 6);
            ula_word   = rand_word();
            ldsd_valid = ($urandom_range(0, 9) < 6);
            ldsd_word  = rand_word();
            model_edge();
            @(posedge clk);
            #1;
            check("random", c, m_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
